ecc_correct_pipe: RTL and testbench
===================================

# ecc_correct_pipe

Downstream correction stage of the decoder. Accepts a codeword together with its two 8-bit syndromes and the error location from the error-location stage, classifies the word as no-error / correctable / uncorrectable, repairs the single bad symbol when correctable, and emits the result through a two-stage valid/ready pipeline. It also keeps saturating CE/UE event counters for status reporting.

## Interface
- NUM_SYM, 8, symbols per codeword (valid locations 0..NUM_SYM-1)
- SYM_W, 8, bits per symbol; must equal syndrome width
- CNT_W, 16, width of each event counter
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept word this cycle
- in_data  input  NUM_SYM*SYM_W  received codeword; symbol i = bits [i*SYM_W +: SYM_W]
- in_syn0  input  8  syndrome 0 (error magnitude when correctable)
- in_syn1  input  8  syndrome 1
- in_loc  input  8  error location from the error-location stage
- out_valid  output  1  corrected word valid
- out_ready  input  1  downstream accepts
- out_data  output  NUM_SYM*SYM_W  corrected (or passed-through) codeword
- out_status  output  2  00 NE, 01 CE, 10 UE; 11 never driven
- cnt_clr  input  1  synchronous clear of both counters
- ce_count  output  CNT_W  correctable words delivered, saturating
- ue_count  output  CNT_W  uncorrectable words delivered, saturating

## Operation
- Classification (stage 1, on acceptance):
  - NE: in_syn0 == 0 and in_syn1 == 0; data unchanged.
  - CE: in_syn0 != 0 and in_loc < NUM_SYM; symbol[in_loc] ^= in_syn0, all other symbols unchanged.
  - UE: all other cases, including in_syn0 == 0 with in_syn1 != 0, and in_loc >= NUM_SYM. Data passed unmodified.
- in_loc comparison is unsigned over the full 8 bits; no truncation before comparison.
- Pipeline: S1 register (classified, corrected word) -> S2 output register. Each stage holds a valid bit.
- S2 loads when !s2_valid or out_ready. S1 advances into S2 under the same condition.
- in_ready = !s1_valid or s1 advances this cycle (combinational from out_ready through the stage chain; no bubble at full throughput).
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- out_data and out_status hold stable while out_valid && !out_ready.
- Counters update only on deliver: +1 to ce_count for CE, +1 to ue_count for UE. Hold at 2^CNT_W-1 (no wrap).
- cnt_clr wins over a simultaneous deliver increment: counter = 0 that cycle, and the delivered word is not counted.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_status 00, ce_count 0, ue_count 0, internal valids 0.
- Latency: word accepted in cycle N appears with out_valid in cycle N+2 when out_ready stays high.
- Throughput: one word per cycle under continuous out_ready.
- Backpressure: with out_ready low, two words are buffered (S1 + S2), then in_ready drops in the same cycle S1 fills.
- out_ready rising with both stages full: S2 delivers, S1 moves to S2, and a new word is accepted in the same cycle.
- Reset mid-operation: buffered words are discarded; no partial delivery and no counter update.

## Structure
- Shared decoder package: status enum (ST_NE=2'b00, ST_CE=2'b01, ST_UE=2'b10), SYM_W constant, default NUM_SYM.
- One sub-module, ecc_pipe_reg: a generic valid/ready register slice (payload width parameter), instantiated twice.
- Classification and correction logic are combinational in the top module, ahead of S1.

## Test plan
- NE word: syn0=0, syn1=0, data=0x0706050403020100, loc=0 -> same data, status 00, counters unchanged, out_valid at cycle N+2.
- CE: syn0=0x5A, loc=3, data symbol3=0x03 -> output symbol3=0x59, others unchanged, status 01, ce_count=1.
- UE cases: loc=8 with syn0=0x11 -> data unchanged, status 10. Separately syn0=0 and syn1=0x22 -> status 10. ue_count=2 after both.
- Backpressure: stream 5 words with out_ready=0 -> in_ready low after 2 accepts. Release out_ready -> all 5 delivered in order, nothing lost or duplicated.
- Saturation/clear: force ce_count to 0xFFFF, deliver a CE -> stays 0xFFFF. Assert cnt_clr in the same cycle as a CE deliver -> ce_count=0.
- Async reset with both stages full -> out_valid=0 and in_ready=1 immediately after reset, counters=0, next word delivers normally.

Source files
------------

// File: rtl/ecc_correct_pipe_pkg.sv
// Shared decoder definitions: status encoding and default geometry for the
// correction stage.
package ecc_correct_pipe_pkg;

  typedef enum logic [1:0] {
    ST_NE = 2'b00,
    ST_CE = 2'b01,
    ST_UE = 2'b10
  } status_e;

  localparam int SYN_W       = 8;
  localparam int DEF_NUM_SYM = 8;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/ecc_correct_pipe_if.sv
// Upstream/downstream handshake bundle of the correction stage.
interface ecc_correct_pipe_if
  import ecc_correct_pipe_pkg::*;
#(
  parameter int NUM_SYM = DEF_NUM_SYM,
  parameter int SYM_W   = SYN_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SYM*SYM_W-1:0] in_data;
  logic [SYN_W-1:0]         in_syn0;
  logic [SYN_W-1:0]         in_syn1;
  logic [7:0]               in_loc;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_SYM*SYM_W-1:0] out_data;
  logic [1:0]               out_status;

  modport master (
    output in_valid, in_data, in_syn0, in_syn1, in_loc, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_data, in_syn0, in_syn1, in_loc, out_ready,
    output in_ready, out_valid, out_data, out_status
  );

endinterface

// File: rtl/ecc_correct_pipe_reg.sv
// Generic valid/ready register slice; full throughput, ready chains
// combinationally from the downstream side.
module ecc_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Payload loads only with a valid word so the output holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ecc_correct_pipe.sv
// Correction stage: classify NE/CE/UE, repair one symbol, two-slice output
// pipeline, saturating CE/UE event counters.
module ecc_correct_pipe
  import ecc_correct_pipe_pkg::*;
#(
  parameter int NUM_SYM = DEF_NUM_SYM,
  parameter int SYM_W   = SYN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  ecc_correct_pipe_if.slave bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_count,
  output logic [CNT_W-1:0] ue_count
);

  localparam int DW = NUM_SYM * SYM_W;
  localparam int PW = DW + 2;

  status_e       cls;
  logic          loc_ok;
  logic [DW-1:0] fixed;
  logic [PW-1:0] s0_payload;
  logic [PW-1:0] s1_payload;
  logic [PW-1:0] s2_payload;
  logic          s1_valid;
  logic          s2_in_ready;
  logic          deliver;

  always_comb begin
    loc_ok = 32'(bus.in_loc) < NUM_SYM;
    cls    = ST_UE;
    if (bus.in_syn0 == '0 && bus.in_syn1 == '0) cls = ST_NE;
    else if (bus.in_syn0 != '0 && loc_ok)       cls = ST_CE;
    fixed = bus.in_data;
    for (int unsigned i = 0; i < NUM_SYM; i++) begin
      if (cls == ST_CE && bus.in_loc == 8'(i))
        fixed[i*SYM_W +: SYM_W] = bus.in_data[i*SYM_W +: SYM_W] ^ bus.in_syn0;
    end
    s0_payload = {cls, fixed};
  end

  ecc_pipe_reg #(.W(PW)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s0_payload),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_payload)
  );

  ecc_pipe_reg #(.W(PW)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s1_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_payload)
  );

  assign bus.out_data   = s2_payload[DW-1:0];
  assign bus.out_status = s2_payload[DW+1:DW];
  assign deliver        = bus.out_valid && bus.out_ready;

  // Clear takes priority: a word delivered in the clear cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (cnt_clr) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (deliver) begin
      if (bus.out_status == ST_CE && ce_count != '1) ce_count <= ce_count + 1'b1;
      if (bus.out_status == ST_UE && ue_count != '1) ue_count <= ue_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_correct_pipe.sv
// Directed + randomized bench for ecc_correct_pipe against a queue-based
// reference model of the classification rules.
module tb_ecc_correct_pipe;
  import ecc_correct_pipe_pkg::*;

  localparam int NSYM = 8;
  localparam int DW   = NSYM * SYN_W;
  localparam int CW   = 4;                 // narrow counters make saturation reachable
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] ce_count;
  logic [CW-1:0] ue_count;

  int n_vec = 0;
  int n_err = 0;
  int ce_m  = 0;
  int ue_m  = 0;
  logic [DW+1:0] exp_q[$];

  ecc_correct_pipe_if #(.NUM_SYM(NSYM), .SYM_W(SYN_W)) bus ();

  ecc_correct_pipe #(.NUM_SYM(NSYM), .SYM_W(SYN_W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .ce_count (ce_count),
    .ue_count (ue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+1:0] ref_word(input logic [DW-1:0] d, input logic [7:0] s0,
                                             input logic [7:0] s1, input logic [7:0] loc);
    logic [7:0]    sym[NSYM];
    logic [DW-1:0] r;
    if (s0 == 8'd0 && s1 == 8'd0) return {ST_NE, d};
    if (s0 == 8'd0 || int'(loc) >= NSYM) return {ST_UE, d};
    for (int i = 0; i < NSYM; i++) sym[i] = d[i*8 +: 8];
    sym[int'(loc)] = sym[int'(loc)] ^ s0;
    for (int i = 0; i < NSYM; i++) r[i*8 +: 8] = sym[i];
    return {ST_CE, r};
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [7:0] s0,
                      input logic [7:0] s1, input logic [7:0] loc, input logic ordy,
                      input logic clr, output logic acc, output logic ov);
    logic          dlv;
    logic [DW+1:0] popped;
    logic [DW+1:0] got;
    popped = '0;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_syn0   = s0;
    bus.in_syn1   = s1;
    bus.in_loc    = loc;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    #1;
    acc = v && bus.in_ready;
    ov  = bus.out_valid;
    dlv = bus.out_valid && ordy;
    got = {bus.out_status, bus.out_data};
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check("out_valid_unexpected", 80'(bus.out_valid), 80'(0));
      else check("out_word", 80'(got), 80'(exp_q[0]));
    end
    if (dlv && exp_q.size() > 0) popped = exp_q.pop_front();
    if (acc) exp_q.push_back(ref_word(d, s0, s1, loc));
    @(posedge clk);
    #1;
    if (clr) begin
      ce_m = 0;
      ue_m = 0;
    end else if (dlv) begin
      if (popped[DW+1:DW] == ST_CE && ce_m < CMAX) ce_m++;
      if (popped[DW+1:DW] == ST_UE && ue_m < CMAX) ue_m++;
    end
    check("ce_count", 80'(ce_count), 80'(ce_m));
    check("ue_count", 80'(ue_count), 80'(ue_m));
  endtask

  task automatic drain();
    logic a, o;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, a, o);
    check("drain_empty", 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    logic          a, o;
    logic [DW-1:0] base;
    logic [DW-1:0] d;
    logic [7:0]    s0, s1, loc;
    int            nacc, idx;
    logic [DW-1:0] bp_words[5];

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_syn0 = '0; bus.in_syn1 = '0;
    bus.in_loc = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   80'(bus.in_ready),   80'(1));
    check("rst_out_valid",  80'(bus.out_valid),  80'(0));
    check("rst_out_data",   80'(bus.out_data),   80'(0));
    check("rst_out_status", 80'(bus.out_status), 80'(0));
    check("rst_ce",         80'(ce_count),       80'(0));
    check("rst_ue",         80'(ue_count),       80'(0));
    rst_n = 1'b1;

    // NE word and two-cycle latency
    base = 64'h0706050403020100;
    step(1'b1, base, 8'h00, 8'h00, 8'd0, 1'b1, 1'b0, a, o);
    check("ne_accept", 80'(a), 80'(1));
    step(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, a, o);
    check("lat_n1_no_valid", 80'(o), 80'(0));
    step(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, a, o);
    check("lat_n2_valid", 80'(o), 80'(1));

    // CE at symbol 3: 0x03 ^ 0x5A = 0x59
    step(1'b1, base, 8'h5A, 8'h00, 8'd3, 1'b1, 1'b0, a, o);
    drain();
    check("ce_one", 80'(ce_count), 80'(1));
    check("ce_last_data", 80'(bus.out_data), 80'(64'h0706050459020100));

    // UE: out-of-range location, then syn0 == 0 with syn1 != 0
    step(1'b1, base, 8'h11, 8'h00, 8'd8, 1'b1, 1'b0, a, o);
    step(1'b1, base, 8'h00, 8'h22, 8'd2, 1'b1, 1'b0, a, o);
    drain();
    check("ue_two", 80'(ue_count), 80'(2));

    // Backpressure: five words offered with out_ready low
    for (int i = 0; i < 5; i++) bp_words[i] = {$urandom(), $urandom()};
    nacc = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, bp_words[idx], 8'h00, 8'h00, 8'd0, 1'b0, 1'b0, a, o);
      if (a) begin nacc++; idx++; end
    end
    check("bp_accepts", 80'(nacc), 80'(2));
    check("bp_in_ready_low", 80'(bus.in_ready), 80'(0));
    for (int c = 0; c < 20 && idx < 5; c++) begin
      step(1'b1, bp_words[idx], 8'h00, 8'h00, 8'd0, 1'b1, 1'b0, a, o);
      if (a) idx++;
    end
    check("bp_all_accepted", 80'(idx), 80'(5));
    drain();

    // Saturation, then clear colliding with a CE delivery
    step(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, a, o);
    for (int i = 0; i < CMAX + 5; i++)
      step(1'b1, {$urandom(), $urandom()}, 8'($urandom_range(255, 1)), 8'($urandom), 8'($urandom_range(NSYM-1)), 1'b1, 1'b0, a, o);
    drain();
    check("ce_saturated", 80'(ce_count), 80'(CMAX));
    step(1'b1, base, 8'h01, 8'h00, 8'd0, 1'b1, 1'b0, a, o);
    step(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, a, o);
    step(1'b0, '0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, a, o);
    check("clr_deliver_valid", 80'(o), 80'(1));
    check("clr_wins", 80'(ce_count), 80'(0));

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      d   = {$urandom(), $urandom()};
      s0  = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      s1  = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      loc = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(NSYM-1));
      step(1'($urandom_range(1)), d, s0, s1, loc, ($urandom_range(3) != 0),
           ($urandom_range(63) == 0), a, o);
    end

    // Async reset with both stages full
    for (int i = 0; i < 3; i++)
      step(1'b1, {$urandom(), $urandom()}, 8'h33, 8'h00, 8'd1, 1'b0, 1'b0, a, o);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 80'(bus.out_valid), 80'(0));
    check("arst_in_ready",  80'(bus.in_ready),  80'(1));
    check("arst_ce",        80'(ce_count),      80'(0));
    check("arst_ue",        80'(ue_count),      80'(0));
    exp_q.delete();
    ce_m = 0; ue_m = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, base, 8'h44, 8'h00, 8'd7, 1'b1, 1'b0, a, o);
    drain();
    check("post_rst_ce", 80'(ce_count), 80'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
